vid_tmds_encoder: RTL



---
 rtl/vid_tmds_pkg.sv | 37 +++
 rtl/vid_tmds_encoder_if.sv | 26 ++
 rtl/tmds_channel.sv | 82 ++++++++
 rtl/vid_tmds_encoder.sv | 61 ++++++
 4 files changed

// File: rtl/vid_tmds_pkg.sv
// Shared constants and helpers for the TMDS encoder: symbol widths, control
// symbols, clock pattern and small bit-counting/expansion functions.
package vid_tmds_pkg;

  localparam int IN_W         = 5;
  localparam int DATA_W       = 8;
  localparam int SYM_W        = 10;
  localparam int TMDS_LATENCY = 3;

  localparam logic [SYM_W-1:0] TMDS_CTRL_00     = 10'b1101010100;
  localparam logic [SYM_W-1:0] TMDS_CTRL_01     = 10'b0010101011;
  localparam logic [SYM_W-1:0] TMDS_CTRL_10     = 10'b0101010100;
  localparam logic [SYM_W-1:0] TMDS_CTRL_11     = 10'b1010101011;
  localparam logic [SYM_W-1:0] TMDS_CLK_PATTERN = 10'b0000011111;

  function automatic logic [3:0] popcount8(input logic [DATA_W-1:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < DATA_W; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  function automatic logic [SYM_W-1:0] ctrl_symbol(input logic [1:0] c);
    case (c)
      2'b00:   return TMDS_CTRL_00;
      2'b01:   return TMDS_CTRL_01;
      2'b10:   return TMDS_CTRL_10;
      default: return TMDS_CTRL_11;
    endcase
  endfunction

  // Replicating the top bits maps full-scale 5-bit to full-scale 8-bit.
  function automatic logic [DATA_W-1:0] expand5(input logic [IN_W-1:0] x);
    return {x, x[4:2]};
  endfunction

endpackage

// File: rtl/vid_tmds_encoder_if.sv
// Pixel/sync/blank bundle from the framebuffer and the TMDS symbol outputs.
interface vid_tmds_encoder_if;
  import vid_tmds_pkg::*;

  logic [IN_W-1:0]  VGA_R;
  logic [IN_W-1:0]  VGA_G;
  logic [IN_W-1:0]  VGA_B;
  logic             VGA_HS;
  logic             VGA_VS;
  logic             VGA_BLANK;
  logic [SYM_W-1:0] tmds_r;
  logic [SYM_W-1:0] tmds_g;
  logic [SYM_W-1:0] tmds_b;
  logic [SYM_W-1:0] tmds_clk;

  modport master (
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK,
    input  tmds_r, tmds_g, tmds_b, tmds_clk
  );

  modport slave (
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK,
    output tmds_r, tmds_g, tmds_b, tmds_clk
  );

endinterface

// File: rtl/tmds_channel.sv
// One TMDS channel: transition minimisation (stage 2) and DC balancing with
// a running disparity counter (stage 3). Blanking emits control symbols.
module tmds_channel
  import vid_tmds_pkg::*;
(
  input  logic              clk_vga,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        ctrl,
  input  logic              blank,
  output logic [SYM_W-1:0]  symbol
);

  logic [3:0]        n1_data;
  logic              use_xnor;
  logic [8:0]        q_m_next;
  logic [8:0]        q_m_reg;
  logic [3:0]        n1q_reg;
  logic [3:0]        n0q_reg;
  logic [1:0]        ctrl_reg;
  logic              blank_reg;
  logic signed [5:0] cnt_reg;
  logic signed [5:0] cnt_next;
  logic [SYM_W-1:0]  symbol_next;
  logic signed [5:0] diff;
  logic signed [5:0] q8_x2;
  logic signed [5:0] nq8_x2;

  assign n1_data  = popcount8(data);
  assign use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);

  always_comb begin
    q_m_next    = '0;
    q_m_next[0] = data[0];
    for (int i = 1; i < DATA_W; i++)
      q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ data[i]) : (q_m_next[i-1] ^ data[i]);
    q_m_next[8] = ~use_xnor;
  end

  assign diff   = $signed({2'b00, n1q_reg}) - $signed({2'b00, n0q_reg});
  assign q8_x2  = $signed({4'b0000, q_m_reg[8], 1'b0});
  assign nq8_x2 = $signed({4'b0000, ~q_m_reg[8], 1'b0});

  always_comb begin
    symbol_next = ctrl_symbol(ctrl_reg);
    cnt_next    = '0;
    if (!blank_reg) begin
      if (cnt_reg == 6'sd0 || n1q_reg == n0q_reg) begin
        symbol_next = {~q_m_reg[8], q_m_reg[8], q_m_reg[8] ? q_m_reg[7:0] : ~q_m_reg[7:0]};
        cnt_next    = q_m_reg[8] ? cnt_reg + diff : cnt_reg - diff;
      end else if ((cnt_reg > 6'sd0 && n1q_reg > n0q_reg) ||
                   (cnt_reg < 6'sd0 && n0q_reg > n1q_reg)) begin
        symbol_next = {1'b1, q_m_reg[8], ~q_m_reg[7:0]};
        cnt_next    = cnt_reg + q8_x2 - diff;
      end else begin
        symbol_next = {1'b0, q_m_reg[8], q_m_reg[7:0]};
        cnt_next    = cnt_reg - nq8_x2 + diff;
      end
    end
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      q_m_reg   <= '0;
      n1q_reg   <= '0;
      n0q_reg   <= '0;
      ctrl_reg  <= '0;
      blank_reg <= 1'b1;
      cnt_reg   <= '0;
      symbol    <= TMDS_CTRL_00;
    end else begin
      q_m_reg   <= q_m_next;
      n1q_reg   <= popcount8(q_m_next[7:0]);
      n0q_reg   <= 4'd8 - popcount8(q_m_next[7:0]);
      ctrl_reg  <= ctrl;
      blank_reg <= blank;
      cnt_reg   <= cnt_next;
      symbol    <= symbol_next;
    end
  end

endmodule

// File: rtl/vid_tmds_encoder.sv
// RGB555 + sync/blank to three TMDS symbol streams, 3-clock fixed latency.
// Stage 1 lives here; stages 2-3 are per-channel.
module vid_tmds_encoder
  import vid_tmds_pkg::*;
(
  input  logic          clk_vga,
  input  logic          reset,
  vid_tmds_encoder_if.slave vid
);

  logic [DATA_W-1:0] r_reg, g_reg, b_reg;
  logic              hs_reg, vs_reg, blank_reg;
  logic [DATA_W-1:0] chan_data [3];
  logic [1:0]        chan_ctrl [3];
  logic [SYM_W-1:0]  chan_sym  [3];

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      r_reg     <= '0;
      g_reg     <= '0;
      b_reg     <= '0;
      hs_reg    <= 1'b0;
      vs_reg    <= 1'b0;
      blank_reg <= 1'b1;
    end else begin
      r_reg     <= expand5(vid.VGA_R);
      g_reg     <= expand5(vid.VGA_G);
      b_reg     <= expand5(vid.VGA_B);
      hs_reg    <= vid.VGA_HS;
      vs_reg    <= vid.VGA_VS;
      blank_reg <= vid.VGA_BLANK;
    end
  end

  // Channel 0 = blue carries the syncs; green and red send C=00 in blanking.
  assign chan_data[0] = b_reg;
  assign chan_data[1] = g_reg;
  assign chan_data[2] = r_reg;
  assign chan_ctrl[0] = {vs_reg, hs_reg};
  assign chan_ctrl[1] = 2'b00;
  assign chan_ctrl[2] = 2'b00;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      tmds_channel u_chan (
        .clk_vga (clk_vga),
        .reset   (reset),
        .data    (chan_data[gi]),
        .ctrl    (chan_ctrl[gi]),
        .blank   (blank_reg),
        .symbol  (chan_sym[gi])
      );
    end
  endgenerate

  assign vid.tmds_b   = chan_sym[0];
  assign vid.tmds_g   = chan_sym[1];
  assign vid.tmds_r   = chan_sym[2];
  assign vid.tmds_clk = TMDS_CLK_PATTERN;

endmodule
